// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Runs a 32-step shift-add or restoring divide, then one sign-fix cycle.
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [2:0]  mdop_i,
  input  logic [31:0] src0_i,
  input  logic [31:0] src1_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_dz;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_abs0;
  logic [31:0] w_abs1;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [63:0] w_prod_neg;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_signed = (mdop_i == 3'b000) || (mdop_i == 3'b010);
  // Two's-complement negation leaves 0x80000000 as its own magnitude.
  assign w_abs0   = (w_signed && src0_i[31]) ? (32'd0 - src0_i) : src0_i;
  assign w_abs1   = (w_signed && src1_i[31]) ? (32'd0 - src1_i) : src1_i;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  assign w_div_sh   = {r_acc[63:32], r_acc[31]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_b};
  assign w_div_rem  = w_div_sh[31:0] - r_b;

  assign w_prod_neg = 64'd0 - r_acc;
  assign w_q        = r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
  assign w_r        = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            if (!mdop_i[2]) begin
              r_div   <= mdop_i[1];
              r_cnt   <= 5'd0;
              r_b     <= w_abs1;
              r_neg_q <= w_signed && (src0_i[31] ^ src1_i[31]);
              r_neg_r <= w_signed && src0_i[31];
              if (mdop_i[1] && (src1_i == 32'd0)) begin
                // Divide by zero skips the loop; result is preloaded raw.
                r_dz    <= 1'b1;
                r_acc   <= {src0_i, 32'hFFFF_FFFF};
                r_state <= S_FIX;
              end else begin
                r_dz    <= 1'b0;
                r_acc   <= {32'd0, w_abs0};
                r_state <= S_CALC;
              end
            end else if (mdop_i == 3'b100) begin
              r_hi <= src0_i;
            end else if (mdop_i == 3'b101) begin
              r_lo <= src0_i;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            if (r_div)
              r_acc <= w_div_ge ? {w_div_rem, r_acc[30:0], 1'b1}
                                : {w_div_sh[31:0], r_acc[30:0], 1'b0};
            else
              r_acc <= {w_mul_sum, r_acc[31:1]};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush_i) begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_hi <= r_acc[63:32];
              r_lo <= r_acc[31:0];
            end else if (r_div) begin
              r_hi <= w_r;
              r_lo <= w_q;
            end else begin
              {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == S_CALC) || (r_state == S_FIX);
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [2:0]  mdop_i;
  logic [31:0] src0_i;
  logic [31:0] src1_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .mdop_i(mdop_i),
    .src0_i(src0_i), .src1_i(src1_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics from plain integer arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo);
    longint sa, sb, p;
    logic [63:0] up;
    int q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      3'b000: begin p = sa * sb; {hi, lo} = p; end
      3'b001: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      3'b010: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0; lo = 32'h8000_0000;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          hi = r; lo = q;
        end
      end
      3'b011: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: ;
    endcase
  endfunction

  // Issue one mul/div, check busy/done timing each cycle and the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    logic [31:0] ehi, elo;
    int lat;
    ref_md(op, a, b, ehi, elo);
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    start_i = 1'b1; mdop_i = op; src0_i = a; src1_i = b;
    step();
    start_i = 1'b0; src0_i = $urandom; src1_i = $urandom;
    for (int c = 1; c <= lat; c++) begin
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s timing cyc=%0d busy=%b done=%b expected busy=1 done=0",
                 name, c, busy_o, done_o);
      end
      step();
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done cyc=%0d busy=%b done=%b expected busy=0 done=1",
               name, lat + 1, busy_o, done_o);
    end
    checks++;
    if (hi_o !== ehi || lo_o !== elo) begin
      errors++;
      $display("FAIL %s result hi=%h lo=%h expected hi=%h lo=%h (a=%h b=%h)",
               name, hi_o, lo_o, ehi, elo, a, b);
    end
  endtask

  task automatic write_hl(input logic [2:0] op, input logic [31:0] d);
    start_i = 1'b1; mdop_i = op; src0_i = d;
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    mdop_i = 3'b111; src0_i = 32'd0; src1_i = 32'd0;
    step(); step();
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset hi=%h lo=%h busy=%b done=%b expected all zero",
               hi_o, lo_o, busy_o, done_o);
    end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_op(3'b000, 32'hFFFF_FFFF, 32'd7,        "mult_m1x7");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2,        "div_m7_2");
    run_op(3'b011, 32'd7,         32'd2,        "divu_7_2");
    run_op(3'b010, 32'd7,         32'hFFFF_FFFE, "div_7_m2");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'b011, 32'd5,         32'd0,        "divu_by0");
    run_op(3'b010, 32'hFFFF_FFF0, 32'd0,        "div_by0_neg");
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] hold;
    write_hl(3'b100, 32'h1234_5678);
    checks++;
    if (hi_o !== 32'h1234_5678 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL mthi hi=%h busy=%b done=%b expected hi=12345678 busy=0 done=0",
               hi_o, busy_o, done_o);
    end
    write_hl(3'b101, 32'h9ABC_DEF0);
    checks++;
    if (lo_o !== 32'h9ABC_DEF0 || hi_o !== 32'h1234_5678 || busy_o !== 1'b0 ||
        done_o !== 1'b0) begin
      errors++;
      $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b expected 12345678/9abcdef0 0 0",
               hi_o, lo_o, busy_o, done_o);
    end
    // MTHI while busy must not touch HI
    hold = hi_o;
    write_hl(3'b000, 32'd3);
    for (int i = 0; i < 4; i++) step();
    write_hl(3'b100, 32'hDEAD_BEEF);
    checks++;
    if (hi_o !== hold || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mthi_busy hi=%h busy=%b expected hi=%h busy=1", hi_o, busy_o, hold);
    end
    for (int i = 0; i < 30; i++) step();
  endtask

  task automatic test_flush();
    int seen_done;
    write_hl(3'b100, 32'hA);
    write_hl(3'b101, 32'hB);
    start_i = 1'b1; mdop_i = 3'b000; src0_i = 32'd123; src1_i = 32'd456;
    step();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'hA || lo_o !== 32'hB) begin
      errors++;
      $display("FAIL flush_calc busy=%b hi=%h lo=%h expected busy=0 hi=a lo=b",
               busy_o, hi_o, lo_o);
    end
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o === 1'b1) seen_done++;
      step();
    end
    checks++;
    if (seen_done != 0 || hi_o !== 32'hA || lo_o !== 32'hB) begin
      errors++;
      $display("FAIL flush_nodone dones=%0d hi=%h lo=%h expected 0 a b",
               seen_done, hi_o, lo_o);
    end
    flush_i = 1'b1;
    write_hl(3'b100, 32'h55);
    checks++;
    if (hi_o !== 32'hA || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_mthi hi=%h busy=%b expected hi=a busy=0", hi_o, busy_o);
    end
    write_hl(3'b011, 32'd9);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_start busy=%b expected 0", busy_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    write_hl(3'b100, 32'h77);
    start_i = 1'b1; mdop_i = 3'b011; src0_i = 32'd1000; src1_i = 32'd7;
    step();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) step();
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b expected all zero",
               hi_o, lo_o, busy_o, done_o);
    end
    run_op(3'b001, 32'd3, 32'd5, "multu_3x5");
  endtask

  // Random ops issued back to back: each starts in the previous done cycle.
  task automatic test_back_to_back_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = {1'b1, 31'($urandom)};
        default: ;
      endcase
      run_op(op, a, b, "random");
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_flush();
    test_reset_mid();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO. The single-cycle ALU handles 32-bit arithmetic, logic and shift. This block sits beside it in EX. It accepts one operation from decode/EX and runs a 32-step shift-add or restoring-divide loop. It holds `busy_o` so the pipeline can stall MFHI/MFLO and further mul/div issues.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clk_i` in 1: single clock, all state updates on the rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: issue strobe, sampled every edge.
- `mdop_i` in 3: operation select.
  - 3'b000 MULT, 3'b001 MULTU, 3'b010 DIV, 3'b011 DIVU, 3'b100 MTHI, 3'b101 MTLO.
  - Other codes are NOP.
- `src0_i` in 32: rs (multiplicand / dividend / MTHI/MTLO data).
- `src1_i` in 32: rt (multiplier / divisor).
- `flush_i` in 1: exception cancel; aborts any in-flight operation.
- `busy_o` out 1: operation in progress; HI/LO not yet valid.
- `done_o` out 1: one-cycle pulse, HI/LO just updated by a MULT/DIV.
- `hi_o` out 32: HI register (product[63:32] / remainder).
- `lo_o` out 32: LO register (product[31:0] / quotient).

## Operation
- States: IDLE, CALC, FIX.
- **IDLE:**
  - Accepts `start_i` with a valid `mdop_i` when `flush_i`=0.
  - MULT/DIV variants: latch operand magnitudes and sign flags, clear the 5-bit step counter, go to CALC.
  - Signed ops take the absolute value, computed as unsigned two's-complement negation, so 0x80000000 stays 0x80000000.
  - Unsigned ops take operands as-is.
- **Divisor zero:** DIV/DIVU with `src1_i`=0 goes IDLE→FIX directly.
  - Result: LO=0xFFFFFFFF, HI=`src0_i` (raw, no sign fix).
- **MTHI/MTLO:** write HI/LO with `src0_i` at the accepting edge. `busy_o` stays 0 and `done_o` is not asserted.
- **CALC, multiply:** 64-bit accumulator, shift-add one multiplier bit per cycle, 32 cycles (counter 0..31).
- **CALC, divide:** restoring division, one quotient bit per cycle, 32 cycles. Uses a 33-bit partial remainder compare/subtract.
- **CALC exit:** at counter=31 go to FIX.
- **FIX:** one cycle.
  - Multiply: negate the 64-bit product if the signed op has differing operand signs.
  - Divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI/LO at the FIX→IDLE edge.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No exception is raised; mul/div never flags overflow.
- **Ignored inputs:**
  - `start_i` while `busy_o`=1 is ignored; the pipeline guarantees it does not occur.
  - MTHI/MTLO while busy is ignored.
- **Flush:**
  - `flush_i`=1 in CALC/FIX returns to IDLE at the next edge.
  - HI/LO keep their pre-operation values, and no `done_o` pulse occurs.
  - `flush_i` and `start_i` in the same IDLE cycle: flush wins and nothing is accepted, MTHI/MTLO included.
- **Reset:**
  - `rst_n_i`=0 at an edge forces IDLE, HI=LO=0, `busy_o`=0, `done_o`=0, counter=0.
  - Applies mid-operation too; the in-flight result is lost.

## Timing
- Cycle 0 = the cycle `start_i` is sampled high in IDLE.
- **MULT/MULTU/DIV/DIVU (nonzero divisor):**
  - `busy_o`=1 in cycles 1..33 (32 CALC + 1 FIX).
  - HI/LO updated at the end of cycle 33.
  - `done_o`=1 in cycle 34 only, with new HI/LO visible on `hi_o`/`lo_o`.
- **Divide-by-zero:** `busy_o`=1 in cycle 1 only; `done_o`=1 in cycle 2.
- **MTHI/MTLO:** new value on `hi_o`/`lo_o` in cycle 1.
- **Back-to-back:** a new `start_i` may be accepted in the same cycle `done_o` is high.
- `busy_o` is a decode of state (CALC or FIX). `done_o` is registered. `hi_o`/`lo_o` come directly from registers. No combinational path from inputs to outputs.
- Operands are captured at acceptance; `src0_i`/`src1_i` may change freely afterward.

## Test plan
- MULT src0=0xFFFFFFFF, src1=7 → `busy_o` high cycles 1..33, `done_o` cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFF9. Then MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 7/0xFFFFFFFE (−2) → LO=0xFFFFFFFD, HI=1.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → `done_o` in cycle 2, LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → `hi_o`/`lo_o` update the cycle after each. `busy_o`/`done_o` stay 0. MTHI issued while busy → HI unchanged.
- MULT with HI/LO = 0xA/0xB, `flush_i` in cycle 10 → `busy_o`=0 from cycle 11, no `done_o`, HI/LO remain 0xA/0xB. `start_i`+`flush_i` together in IDLE → nothing accepted.
- `rst_n_i` low in cycle 20 of a DIVU → next cycle HI=LO=0, `busy_o`=0. A fresh MULTU 3×5 then gives LO=15, HI=0 in cycle 34.
